// File: rtl/ext_gpio_ctrl.sv
// Memory-mapped GPIO bank on the EXT bus: atomic output ops,
// synchronised/debounced inputs, sticky edge status and level irq.
module ext_gpio_ctrl #(
    parameter int unsigned AWIDTH         = 16,
    parameter logic [AWIDTH-1:0] ADDR_BASE = '0,
    parameter int unsigned OUT_W          = 4,
    parameter int unsigned IN_W           = 8,
    parameter logic [OUT_W-1:0] OUT_RESET = '0,
    parameter int unsigned SAMPLE_CNT     = 25000,
    parameter int unsigned STABLE_SAMPLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EXT_EN,
    input  logic [3:0]        EXT_WEA,
    input  logic [AWIDTH-1:0] EXT_ADDR,
    input  logic [31:0]       EXT_DIN,
    output logic [31:0]       EXT_DOUT,
    input  logic [IN_W-1:0]   gpio_in,
    output logic [OUT_W-1:0]  gpio_out,
    output logic              irq
);

    localparam int unsigned TW = (SAMPLE_CNT > 1) ? $clog2(SAMPLE_CNT) : 1;
    localparam int unsigned SW = $clog2(STABLE_SAMPLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_CNT - 1);
    localparam logic [SW-1:0] ST_LAST = SW'(STABLE_SAMPLES - 1);
    // rise bits in [15:0], fall bits in [31:16]
    localparam logic [15:0] HMASK = 16'((32'd1 << IN_W) - 1);
    localparam logic [31:0] EMASK = {HMASK, HMASK};

    logic                      hit;
    logic                      wr;
    logic                      rd;
    logic [3:0]                offset;
    logic [31:0]               wmask;
    logic [31:0]               wbits;
    logic [31:0]               rdata;
    logic [31:0]               clr;
    logic [31:0]               ev;
    logic                      tick;

    logic [OUT_W-1:0]          out_q, out_d;
    logic [IN_W-1:0]           sync_q, raw_q;
    logic [IN_W-1:0]           in_q, in_d;
    logic [IN_W-1:0][SW-1:0]   scnt_q, scnt_d;
    logic [TW-1:0]             tcnt_q;
    logic [31:0]               sts_q, sts_d;
    logic [31:0]               ien_q, ien_d;
    logic                      irq_q;

    assign hit    = EXT_EN && (EXT_ADDR[AWIDTH-1:4] == ADDR_BASE[AWIDTH-1:4]);
    assign offset = EXT_ADDR[3:0];
    assign wr     = hit && (EXT_WEA != 4'b0000);
    assign rd     = hit && (EXT_WEA == 4'b0000);
    assign wmask  = {{8{EXT_WEA[3]}}, {8{EXT_WEA[2]}},
                     {8{EXT_WEA[1]}}, {8{EXT_WEA[0]}}};
    assign wbits  = EXT_DIN & wmask;
    assign tick   = (tcnt_q == TICK_LAST);

    always_comb begin
        out_d = out_q;
        ien_d = ien_q;
        clr   = '0;
        if (wr) begin
            unique case (offset)
                4'd0:    out_d = (out_q & ~wmask[OUT_W-1:0]) | wbits[OUT_W-1:0];
                4'd1:    out_d = out_q | wbits[OUT_W-1:0];
                4'd2:    out_d = out_q & ~wbits[OUT_W-1:0];
                4'd3:    out_d = out_q ^ wbits[OUT_W-1:0];
                4'd6:    clr   = wbits;
                4'd7:    ien_d = ((ien_q & ~wmask) | wbits) & EMASK;
                default: ;
            endcase
        end
    end

    // Per-bit run length of samples that disagree with the accepted level
    always_comb begin
        in_d   = in_q;
        scnt_d = scnt_q;
        if (tick) begin
            for (int i = 0; i < int'(IN_W); i++) begin
                if (raw_q[i] != in_q[i]) begin
                    if (scnt_q[i] == ST_LAST) begin
                        in_d[i]   = ~in_q[i];
                        scnt_d[i] = '0;
                    end else begin
                        scnt_d[i] = scnt_q[i] + 1'b1;
                    end
                end else begin
                    scnt_d[i] = '0;
                end
            end
        end
    end

    // New events are OR-ed after the clear so a coincident w1c cannot lose them
    always_comb begin
        ev    = {16'(in_q & ~in_d), 16'(in_d & ~in_q)};
        sts_d = ((sts_q & ~clr) | ev) & EMASK;
    end

    always_comb begin
        rdata = '0;
        unique case (offset)
            4'd0:    rdata = 32'(out_q);
            4'd4:    rdata = 32'(in_q);
            4'd5:    rdata = 32'(raw_q);
            4'd6:    rdata = sts_q;
            4'd7:    rdata = ien_q;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q    <= OUT_RESET;
            sync_q   <= '0;
            raw_q    <= '0;
            in_q     <= '0;
            scnt_q   <= '0;
            tcnt_q   <= '0;
            sts_q    <= '0;
            ien_q    <= '0;
            irq_q    <= 1'b0;
            EXT_DOUT <= '0;
        end else begin
            out_q  <= out_d;
            sync_q <= gpio_in;
            raw_q  <= sync_q;
            in_q   <= in_d;
            scnt_q <= scnt_d;
            tcnt_q <= tick ? '0 : tcnt_q + 1'b1;
            sts_q  <= sts_d;
            ien_q  <= ien_d;
            irq_q  <= |(sts_q & ien_q);
            if (rd) begin
                EXT_DOUT <= rdata;
            end
        end
    end

    assign gpio_out = out_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_ext_gpio_ctrl.sv
// Bench for ext_gpio_ctrl: register-level model compared every cycle,
// plus directed literal checks of the documented scenarios.
module tb_ext_gpio_ctrl;

    localparam int SC = 4;
    localparam int ST = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        EXT_EN = 1'b0;
    logic [3:0]  EXT_WEA = 4'h0;
    logic [15:0] EXT_ADDR = 16'h0;
    logic [31:0] EXT_DIN = 32'h0;
    logic [31:0] EXT_DOUT;
    logic [7:0]  gpio_in = 8'h0;
    logic [15:0] gpio_out;
    logic        irq;

    int checks = 0;
    int errors = 0;

    ext_gpio_ctrl #(
        .AWIDTH(16), .ADDR_BASE(16'h0040), .OUT_W(16), .IN_W(8),
        .OUT_RESET(16'h000A), .SAMPLE_CNT(SC), .STABLE_SAMPLES(ST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .EXT_EN(EXT_EN), .EXT_WEA(EXT_WEA),
        .EXT_ADDR(EXT_ADDR), .EXT_DIN(EXT_DIN), .EXT_DOUT(EXT_DOUT),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state as the programmer sees it
    bit          m_valid = 0;
    logic [15:0] m_out;
    logic [7:0]  m_s1, m_s2, m_in;
    logic [31:0] m_sts, m_ien, m_dout;
    logic        m_irq;
    int          m_tick;
    int          m_run[8];

    always @(posedge clk) begin : model
        logic [31:0] m, d, clr, ev, rdv;
        logic [15:0] n_out;
        logic [31:0] n_ien;
        logic [7:0]  n_in;
        int          n_run[8];
        bit          hit, tk;
        if (!rst_n) begin
            m_valid <= 1;
            m_out <= 16'h000A;
            m_s1 <= '0; m_s2 <= '0; m_in <= '0;
            m_sts <= '0; m_ien <= '0; m_dout <= '0; m_irq <= 0;
            m_tick <= 0;
            for (int i = 0; i < 8; i++) m_run[i] <= 0;
        end else begin
            hit = EXT_EN && (EXT_ADDR[15:4] == 12'h004);
            m = {{8{EXT_WEA[3]}}, {8{EXT_WEA[2]}}, {8{EXT_WEA[1]}}, {8{EXT_WEA[0]}}};
            d = EXT_DIN & m;
            case (EXT_ADDR[3:0])
                4'd0: rdv = {16'h0, m_out};
                4'd4: rdv = {24'h0, m_in};
                4'd5: rdv = {24'h0, m_s2};
                4'd6: rdv = m_sts;
                4'd7: rdv = m_ien;
                default: rdv = 0;
            endcase
            if (hit && EXT_WEA == 0) m_dout <= rdv;
            m_irq <= |(m_sts & m_ien);
            tk = (m_tick == SC - 1);
            m_tick <= tk ? 0 : m_tick + 1;
            n_in = m_in;
            for (int i = 0; i < 8; i++) begin
                n_run[i] = m_run[i];
                if (tk) begin
                    if (m_s2[i] != m_in[i]) begin
                        n_run[i] = m_run[i] + 1;
                        if (n_run[i] >= ST) begin
                            n_in[i] = ~m_in[i];
                            n_run[i] = 0;
                        end
                    end else begin
                        n_run[i] = 0;
                    end
                end
                m_run[i] <= n_run[i];
            end
            n_out = m_out; n_ien = m_ien; clr = 0;
            if (hit && EXT_WEA != 0) begin
                case (EXT_ADDR[3:0])
                    4'd0: n_out = (m_out & ~m[15:0]) | d[15:0];
                    4'd1: n_out = m_out | d[15:0];
                    4'd2: n_out = m_out & ~d[15:0];
                    4'd3: n_out = m_out ^ d[15:0];
                    4'd6: clr = d;
                    4'd7: n_ien = ((m_ien & ~m) | d) & 32'h00FF00FF;
                    default: ;
                endcase
            end
            ev = {8'h0, m_in & ~n_in, 8'h0, n_in & ~m_in};
            m_sts <= (m_sts & ~clr) | ev;
            m_out <= n_out;
            m_ien <= n_ien;
            m_in  <= n_in;
            m_s2  <= m_s1;
            m_s1  <= gpio_in;
        end
    end

    always @(posedge clk) begin
        #2;
        if (m_valid) begin
            chk("gpio_out", {16'h0, gpio_out}, {16'h0, m_out});
            chk("irq", {31'h0, irq}, {31'h0, m_irq});
            chk("EXT_DOUT", EXT_DOUT, m_dout);
        end
    end

    function automatic bit toggle_next(input int i);
        return (m_tick == SC - 1) && (m_s2[i] != m_in[i]) && (m_run[i] == ST - 1);
    endfunction

    task automatic access_now(input logic [3:0] wea, input logic [15:0] addr,
                              input logic [31:0] din);
        EXT_EN = 1'b1; EXT_WEA = wea; EXT_ADDR = addr; EXT_DIN = din;
        @(negedge clk);
        EXT_EN = 1'b0; EXT_WEA = 4'h0; EXT_DIN = 32'h0;
    endtask

    task automatic access(input logic [3:0] wea, input logic [15:0] addr,
                          input logic [31:0] din);
        @(negedge clk);
        access_now(wea, addr, din);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] off,
                          input logic [31:0] exp);
        access(4'h0, {12'h004, off}, 32'h0);
        chk(name, EXT_DOUT, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_in(input logic [7:0] lvl);
        int k;
        for (k = 0; k < 200 && m_in !== lvl; k++) @(negedge clk);
        chk("in_settle_timeout", {24'h0, m_in}, {24'h0, lvl});
    endtask

    initial begin : stim
        logic [31:0] exp_rd [8];
        bit found;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("reset_gpio_out", {16'h0, gpio_out}, 32'h0000000A);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        exp_rd = '{32'hA, 0, 0, 0, 0, 0, 0, 0};
        for (int o = 0; o < 8; o++) rd_chk($sformatf("reset_rd%0d", o), 4'(o), exp_rd[o]);

        // Atomic ops
        access(4'hF, 16'h0040, 32'h5); chk("out_wr", {16'h0, gpio_out}, 32'h5);
        access(4'hF, 16'h0041, 32'h2); chk("out_set", {16'h0, gpio_out}, 32'h7);
        access(4'hF, 16'h0042, 32'h1); chk("out_clr", {16'h0, gpio_out}, 32'h6);
        access(4'hF, 16'h0043, 32'h8); chk("out_tgl", {16'h0, gpio_out}, 32'hE);
        rd_chk("set_reads_0", 4'h1, 32'h0);
        access(4'hF, 16'h0050, 32'h1234);
        chk("other_bank_ignored", {16'h0, gpio_out}, 32'hE);

        // Byte enables and unmapped offset
        access(4'hF, 16'h0040, 32'h0);
        access(4'h1, 16'h0040, 32'hFFFF);
        chk("byte_en", {16'h0, gpio_out}, 32'h00FF);
        rd_chk("unmapped_rd", 4'h9, 32'h0);
        access(4'hF, 16'h0044, 32'hFF);
        rd_chk("in_ro", 4'h4, 32'h0);

        // Debounce: short pulse rejected, held level accepted
        @(negedge clk); gpio_in = 8'h01;
        idle(10); gpio_in = 8'h00;
        idle(20);
        rd_chk("glitch_in", 4'h4, 32'h0);
        rd_chk("glitch_sts", 4'h6, 32'h0);
        gpio_in = 8'h01;
        idle(24);
        rd_chk("held_in", 4'h4, 32'h1);
        rd_chk("held_rise", 4'h6, 32'h1);
        rd_chk("raw", 4'h5, 32'h1);

        // IRQ
        access(4'hF, 16'h0047, 32'h1);
        @(negedge clk); chk("irq_on", {31'h0, irq}, 32'h1);
        access(4'hF, 16'h0046, 32'h1);
        @(negedge clk); chk("irq_off", {31'h0, irq}, 32'h0);
        gpio_in = 8'h00;
        wait_in(8'h00);
        access(4'hF, 16'h0046, 32'hFFFFFFFF);
        gpio_in = 8'h01;
        found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            found = toggle_next(0);
        end
        chk("rise_wait_timeout", {31'h0, found}, 32'h1);
        access_now(4'hF, 16'h0046, 32'h1);
        rd_chk("set_wins", 4'h6, 32'h1);
        chk("irq_after_race", {31'h0, irq}, 32'h1);
        access(4'hF, 16'h0046, 32'h1);
        @(negedge clk); chk("irq_cleared", {31'h0, irq}, 32'h0);

        // Mid-operation reset
        gpio_in = 8'h00;
        wait_in(8'h00);
        gpio_in = 8'h02;
        idle(8);
        rst_n = 1'b0; gpio_in = 8'h00;
        idle(1); rst_n = 1'b1;
        idle(40);
        rd_chk("rst_in", 4'h4, 32'h0);
        rd_chk("rst_sts", 4'h6, 32'h0);
        access(4'hF, 16'h0040, 32'h1234);
        @(negedge clk);
        EXT_EN = 1'b1; EXT_WEA = 4'h0; EXT_ADDR = 16'h0040;
        rst_n = 1'b0;
        @(negedge clk);
        EXT_EN = 1'b0; rst_n = 1'b1;
        chk("rst_dout", EXT_DOUT, 32'h0);
        chk("rst_out", {16'h0, gpio_out}, 32'h000A);
        idle(3);
        chk("rst_dout_hold", EXT_DOUT, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
